// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED running-light sequencer.
package led_seq_pkg;

    localparam int unsigned MODE_W = 3;

    // Pattern modes; codes 5-7 are unused and recovered to MODE_ROT_L.
    typedef enum logic [MODE_W-1:0] {
        MODE_ROT_L  = 3'd0,
        MODE_ROT_R  = 3'd1,
        MODE_BOUNCE = 3'd2,
        MODE_FILL   = 3'd3,
        MODE_BLINK  = 3'd4
    } mode_t;

    // Walking direction of the single lit bit in MODE_BOUNCE.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [7:0] INIT_ROT_L  = 8'h01;
    localparam logic [7:0] INIT_ROT_R  = 8'h80;
    localparam logic [7:0] INIT_BOUNCE = 8'h01;
    localparam logic [7:0] INIT_FILL   = 8'h00;
    localparam logic [7:0] INIT_BLINK  = 8'h00;

    // Pattern loaded into the LEDs when a mode is entered.
    function automatic logic [7:0] init_pattern(input mode_t m);
        case (m)
            MODE_ROT_L:  return INIT_ROT_L;
            MODE_ROT_R:  return INIT_ROT_R;
            MODE_BOUNCE: return INIT_BOUNCE;
            MODE_FILL:   return INIT_FILL;
            MODE_BLINK:  return INIT_BLINK;
            default:     return INIT_ROT_L;
        endcase
    endfunction

    // Mode that follows m on a button press, wrapping BLINK back to ROT_L.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_ROT_L:  return MODE_ROT_R;
            MODE_ROT_R:  return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_FILL;
            MODE_FILL:   return MODE_BLINK;
            default:     return MODE_ROT_L;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse when the accepted level flips from 0 to 1.
module btn_debounce
    import led_seq_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk_50mhz,
    input  logic start,
    input  logic btn_raw,
    output logic btn_rise
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [DW-1:0] stable_cnt;

    // Synchronise, count consecutive cycles differing from the accepted level, flip after DEB_CYCLES.
    always_ff @(posedge clk_50mhz or negedge start) begin
        if (!start) begin
            sync       <= '0;
            level      <= 1'b0;
            stable_cnt <= '0;
            btn_rise   <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            if (sync[1] == level) begin
                stable_cnt <= '0;
                btn_rise   <= 1'b0;
            end else if (stable_cnt == DW'(DEB_CYCLES - 1)) begin
                level      <= sync[1];
                stable_cnt <= '0;
                btn_rise   <= sync[1];
            end else begin
                stable_cnt <= stable_cnt + DW'(1);
                btn_rise   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED running-light sequencer: programmable step timer, pattern-mode FSM
// advanced by a debounced button, and the LED pattern register.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic       clk_50mhz,
    input  logic       start,
    input  logic       mode_btn,
    input  logic [1:0] speed_sel,
    input  logic       pause,
    output logic [7:0] led,
    output logic [2:0] mode,
    output logic       tick
);

    localparam int unsigned CW = $clog2(STEP_DIV);

    typedef logic [CW:0]   lim_t;
    typedef logic [CW-1:0] cnt_t;

    localparam lim_t DIV_FULL = lim_t'(STEP_DIV);

    cnt_t       cnt_q, cnt_d;
    mode_t      mode_q, mode_d;
    logic [7:0] led_q, led_d;
    dir_t       dir_q, dir_d;
    logic       btn_rise;
    lim_t       limit;
    logic       step_due;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk_50mhz(clk_50mhz),
        .start    (start),
        .btn_raw  (mode_btn),
        .btn_rise (btn_rise)
    );

    // Step period shrinks with speed_sel; >= lets a shortened period fire at once.
    assign limit    = DIV_FULL >> speed_sel;
    assign step_due = !pause && ({1'b0, cnt_q} >= (limit - lim_t'(1)));

    // State register for step counter, mode, LED pattern and bounce direction.
    always_ff @(posedge clk_50mhz or negedge start) begin
        if (!start) begin
            cnt_q  <= '0;
            mode_q <= MODE_ROT_L;
            led_q  <= INIT_ROT_L;
            dir_q  <= DIR_LEFT;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
        end
    end

    // Next state: illegal-mode recovery, then button advance, then the timed pattern step.
    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        led_d  = led_q;
        dir_d  = dir_q;
        if (mode_q > MODE_BLINK) begin
            mode_d = MODE_ROT_L;
            led_d  = INIT_ROT_L;
            cnt_d  = '0;
            dir_d  = DIR_LEFT;
        end else if (btn_rise) begin
            mode_d = next_mode(mode_q);
            led_d  = init_pattern(next_mode(mode_q));
            cnt_d  = '0;
            dir_d  = DIR_LEFT;
        end else if (!pause) begin
            if (step_due) begin
                cnt_d = '0;
                case (mode_q)
                    MODE_ROT_L: led_d = {led_q[6:0], led_q[7]};
                    MODE_ROT_R: led_d = {led_q[0], led_q[7:1]};
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_LEFT) begin
                            if (led_q[7]) begin
                                led_d = {1'b0, led_q[7:1]};
                                dir_d = DIR_RIGHT;
                            end else begin
                                led_d = {led_q[6:0], 1'b0};
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d = {led_q[6:0], 1'b0};
                                dir_d = DIR_LEFT;
                            end else begin
                                led_d = {1'b0, led_q[7:1]};
                            end
                        end
                    end
                    MODE_FILL:  led_d = {led_q[6:0], ~led_q[7]};
                    MODE_BLINK: led_d = ~led_q;
                    default:    led_d = led_q;
                endcase
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    // Outputs: a button advance suppresses the coincident step pulse.
    always_comb begin
        tick = step_due & ~btn_rise;
        mode = mode_q;
        led  = led_q;
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (STEP_DIV=8, DEB_CYCLES=4) against a
// sequence-index reference model.
module tb_led_seq_ctrl;

    localparam int unsigned STEP_DIV = 8;
    localparam int unsigned DEB      = 4;

    logic       clk       = 1'b0;
    logic       start     = 1'b1;
    logic       mode_btn  = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic       pause     = 1'b0;
    logic [7:0] led;
    logic [2:0] mode;
    logic       tick;

    int tests_run    = 0;
    int tests_failed = 0;

    led_seq_ctrl #(
        .STEP_DIV  (STEP_DIV),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk_50mhz(clk),
        .start    (start),
        .mode_btn (mode_btn),
        .speed_sel(speed_sel),
        .pause    (pause),
        .led      (led),
        .mode     (mode),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Model: mode number, step index into that mode's sequence, cycles elapsed in the current step,
    // button seen through a 2-cycle delay, accepted level, run length, pending press pulse.
    int m_mode, m_idx, m_e, m_s1, m_s2, m_acc, m_run, m_rise;

    function automatic logic [7:0] pattern(input int md, input int i);
        int k;
        case (md)
            0: return 8'(1 << (i % 8));
            1: return 8'(128 >> (i % 8));
            2: begin
                k = i % 14;
                return (k <= 7) ? 8'(1 << k) : 8'(1 << (14 - k));
            end
            3: begin
                k = i % 16;
                if (k <= 8) return 8'((1 << k) - 1);
                return 8'(255 & ~((1 << (k - 8)) - 1));
            end
            4: return (i % 2 == 1) ? 8'hFF : 8'h00;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic exp_tick();
        int per;
        per = int'(STEP_DIV >> speed_sel);
        return start && !pause && (m_e + 1 >= per) && (m_rise == 0);
    endfunction

    function automatic logic [11:0] exp_out();
        return {pattern(m_mode, m_idx), 3'(m_mode), exp_tick()};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_e = 0;
        m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0; m_rise = 0;
    endtask

    // Advance DUT and model by one clock; returns at the following falling edge.
    task automatic step();
        int per;
        @(posedge clk);
        if (!start) begin
            model_reset();
        end else begin
            per = int'(STEP_DIV >> speed_sel);
            if (m_rise != 0) begin
                m_mode = (m_mode + 1) % 5;
                m_idx  = 0;
                m_e    = 0;
            end else if (!pause) begin
                if (m_e + 1 >= per) begin
                    m_e = 0;
                    m_idx++;
                end else begin
                    m_e++;
                end
            end
            if (m_s2 != m_acc) begin
                m_run++;
                if (m_run == int'(DEB)) begin
                    m_acc  = m_s2;
                    m_rise = m_s2;
                    m_run  = 0;
                end else begin
                    m_rise = 0;
                end
            end else begin
                m_run  = 0;
                m_rise = 0;
            end
            m_s2 = m_s1;
            m_s1 = int'(mode_btn);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 start = 1'b0;
        repeat (3) step();
        #1;
        tests_run++;
        if ({led, mode, tick} !== {8'h01, 3'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state got=%h want=%h", {led, mode, tick}, {8'h01, 3'd0, 1'b0});
        end
        start = 1'b1;
        model_reset();
    endtask

    task automatic test_rotate();
        int ticks = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            tests_run++;
            if ({led, mode, tick} !== exp_out()) begin
                tests_failed++;
                $display("FAIL rotate c=%0d got=%h want=%h", c, {led, mode, tick}, exp_out());
            end
            if (tick) ticks++;
            step();
        end
        tests_run++;
        if (ticks != 8 || led !== 8'h01) begin
            tests_failed++;
            $display("FAIL rotate_wrap ticks=%0d led=%h want ticks=8 led=01", ticks, led);
        end
    endtask

    task automatic test_debounce();
        int hi_len[5] = '{2, 1, 1, 1, 10};
        for (int g = 1; g <= 3; g++) begin
            for (int c = 0; c < g + 6; c++) begin
                mode_btn = (c < g);
                #1;
                tests_run++;
                if ({led, mode, tick} !== exp_out()) begin
                    tests_failed++;
                    $display("FAIL glitch g=%0d c=%0d got=%h want=%h", g, c, {led, mode, tick}, exp_out());
                end
                step();
            end
        end
        tests_run++;
        if (mode !== 3'd0) begin
            tests_failed++;
            $display("FAIL glitch_mode got=%0d want=0", mode);
        end
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < hi_len[p] + 1; c++) begin
                mode_btn = (c < hi_len[p]);
                #1;
                tests_run++;
                if ({led, mode, tick} !== exp_out()) begin
                    tests_failed++;
                    $display("FAIL bounce p=%0d c=%0d got=%h want=%h", p, c, {led, mode, tick}, exp_out());
                end
                step();
            end
        end
        tests_run++;
        if (mode !== 3'd1 || led !== 8'h80) begin
            tests_failed++;
            $display("FAIL bounce_press mode=%0d led=%h want mode=1 led=80", mode, led);
        end
        for (int c = 0; c < 8; c++) step();
    endtask

    task automatic test_modes();
        int  want = 1;
        logic saw_ff;
        speed_sel = 2'd3;
        for (int p = 0; p < 5; p++) begin
            want   = (want + 1) % 5;
            saw_ff = 1'b0;
            for (int c = 0; c < 40; c++) begin
                mode_btn = (c < 7);
                #1;
                tests_run++;
                if ({led, mode, tick} !== exp_out()) begin
                    tests_failed++;
                    $display("FAIL modes p=%0d c=%0d got=%h want=%h", p, c, {led, mode, tick}, exp_out());
                end
                if (led === 8'hFF) saw_ff = 1'b1;
                step();
            end
            tests_run++;
            if (mode !== 3'(want)) begin
                tests_failed++;
                $display("FAIL mode_seq p=%0d got=%0d want=%0d", p, mode, want);
            end
            if (want == 3) begin
                tests_run++;
                if (!saw_ff) begin
                    tests_failed++;
                    $display("FAIL fill_full got=no_FF want=FF_seen");
                end
            end
        end
    endtask

    task automatic test_speed();
        int budget = 0;
        speed_sel = 2'd0;
        #1;
        while (!tick && budget < 20) begin
            step();
            #1;
            budget++;
        end
        tests_run++;
        if (!tick) begin
            tests_failed++;
            $display("FAIL speed_sync got=no_tick want=tick within 20 cycles");
        end
        for (int c = 0; c < 7; c++) step();
        speed_sel = 2'd3;
        #1;
        tests_run++;
        if (tick !== 1'b1 || exp_tick() !== 1'b1) begin
            tests_failed++;
            $display("FAIL speed_up_now got=%b want=1", tick);
        end
        for (int c = 0; c < 24; c++) begin
            if (c == 8) speed_sel = 2'd2;
            #1;
            tests_run++;
            if ({led, mode, tick} !== exp_out()) begin
                tests_failed++;
                $display("FAIL speed c=%0d got=%h want=%h", c, {led, mode, tick}, exp_out());
            end
            step();
        end
    endtask

    task automatic test_pause();
        logic [2:0] m0;
        speed_sel = 2'd1;
        m0 = mode;
        for (int c = 0; c < 20; c++) begin
            pause    = 1'b1;
            mode_btn = (c >= 2 && c < 10);
            #1;
            tests_run++;
            if ({led, mode, tick} !== exp_out() || tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL pause c=%0d got=%h want=%h", c, {led, mode, tick}, exp_out());
            end
            step();
        end
        tests_run++;
        if (mode !== 3'((m0 + 1) % 5) || led !== pattern((m0 + 1) % 5, 0)) begin
            tests_failed++;
            $display("FAIL pause_press mode=%0d led=%h want mode=%0d led=%h",
                     mode, led, (m0 + 1) % 5, pattern((m0 + 1) % 5, 0));
        end
        pause = 1'b0;
    endtask

    task automatic test_coincident();
        int seen = 0;
        speed_sel = 2'd3;
        for (int c = 0; c < 16; c++) begin
            mode_btn = (c < 8);
            #1;
            if (m_rise != 0) begin
                seen++;
                tests_run++;
                if (tick !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL coincident_tick got=%b want=0", tick);
                end
            end
            tests_run++;
            if ({led, mode, tick} !== exp_out()) begin
                tests_failed++;
                $display("FAIL coincident c=%0d got=%h want=%h", c, {led, mode, tick}, exp_out());
            end
            step();
        end
        tests_run++;
        if (seen != 1) begin
            tests_failed++;
            $display("FAIL coincident_rise count=%0d want=1", seen);
        end
    endtask

    task automatic test_reset_mid();
        speed_sel = 2'd0;
        for (int c = 0; c < 11; c++) step();
        start = 1'b0;
        #1;
        tests_run++;
        if ({led, mode, tick} !== {8'h01, 3'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid got=%h want=%h", {led, mode, tick}, {8'h01, 3'd0, 1'b0});
        end
        model_reset();
        #1 start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            tests_run++;
            if ({led, mode, tick} !== exp_out()) begin
                tests_failed++;
                $display("FAIL after_reset c=%0d got=%h want=%h", c, {led, mode, tick}, exp_out());
            end
            step();
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                mode_btn = ~mode_btn;
                hold     = $urandom_range(12, 1);
            end
            hold--;
            pause = ($urandom_range(9, 0) == 0);
            if ($urandom_range(19, 0) == 0) speed_sel = 2'($urandom_range(3, 0));
            #1;
            tests_run++;
            if ({led, mode, tick} !== exp_out()) begin
                tests_failed++;
                $display("FAIL random c=%0d got=%h want=%h", c, {led, mode, tick}, exp_out());
            end
            step();
        end
        pause    = 1'b0;
        mode_btn = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotate();
        test_debounce();
        test_modes();
        test_speed();
        test_pause();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
